servo_pwm_decoder: RTL and testbench
====================================

SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

Interface
REQ-001 Parameter PULSE_MIN, default 6000, clocks of high time that map to position 0 (0.5 ms at 12 MHz).
REQ-002 Parameter STEP, default 94, clocks per position LSB.
REQ-003 Parameter PULSE_MAX, default 36000, high-time limit in clocks; reaching it is an error.
REQ-004 Parameter TIMEOUT, default 360000, clocks without a completed pulse before lock is lost (30 ms).
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 servo_in  input  1  asynchronous servo PWM pulse train.
REQ-008 position  output  8  last decoded position.
REQ-009 valid  output  1  one-cycle strobe when position is updated.
REQ-010 err  output  1  one-cycle strobe when a pulse reaches PULSE_MAX.
REQ-011 locked  output  1  level; high while pulses arrive regularly.

Function
REQ-012 servo_in SHALL pass a 2-flop synchronizer; edges are detected on the synchronized signal (s_in) against its previous value.
REQ-013 The FSM SHALL have states IDLE, OFFSET, MEASURE, WAIT_LOW.
REQ-014 IDLE: s_in rising edge -> OFFSET, clearing width counter and step counter.
REQ-015 OFFSET: counts clocks; at PULSE_MIN clocks -> MEASURE; falling edge first -> result 0, back to IDLE.
REQ-016 MEASURE: STEP-clock prescaler increments the step counter, saturating at 255; falling edge -> result = step counter, back to IDLE.
REQ-017 Result SHALL equal min(floor((W - PULSE_MIN)/STEP), 255) for W >= PULSE_MIN, else 0, where W = high clocks of s_in.
REQ-018 position and valid SHALL update on the clock after the falling edge is detected; position is held otherwise.
REQ-019 Width counter reaching PULSE_MAX in OFFSET/MEASURE SHALL pulse err for one cycle, clear locked, enter WAIT_LOW, and produce no valid.
REQ-020 WAIT_LOW: ignores s_in until it is low, then -> IDLE.
REQ-021 locked SHALL set with each valid; the timeout counter resets on each valid and clears locked when it reaches TIMEOUT.
REQ-022 valid and timeout in the same cycle: valid wins and locked stays 1.
REQ-023 Counters SHALL be wide enough for max(PULSE_MAX, TIMEOUT) and SHALL never wrap.

Reset
REQ-024 rst high SHALL asynchronously force position=0, valid=0, err=0, locked=0, the synchronizer to 0, the counters to 0 and the FSM to WAIT_LOW.
REQ-025 After rst release, a pulse already high SHALL be ignored; measurement starts at the next rising edge.

Configuration
REQ-026 With SERVO_DEC_FILTER_EN defined, s_in SHALL change only after 4 consecutive equal synchronizer samples, adding 3 clocks of latency per edge; glitches of 3 or fewer clocks are rejected.
REQ-027 Without SERVO_DEC_FILTER_EN, s_in SHALL be the plain 2-flop synchronizer output.

Verification
REQ-028 Defaults, 18000-clock pulse, 20 ms period -> valid once per pulse, position=127, locked=1, err=0.
REQ-029 4800-clock pulse -> position=0 with valid; 29970-clock pulse -> 255; 34000-clock pulse -> 255 (saturated).
REQ-030 40000-clock pulse -> err at the 36000th high clock, no valid, locked=0, next 18000-clock pulse -> position=127, locked=1.
REQ-031 Lock established, then servo_in held low -> locked falls exactly TIMEOUT clocks after the last valid, and position is retained.
REQ-032 rst asserted 5000 clocks into a pulse, released while high -> all outputs 0, no valid for that pulse, next pulse decodes normally.
REQ-033 With SERVO_DEC_FILTER_EN, a 3-clock high glitch -> no FSM activity; a 6000+94*10-clock pulse -> position=10.

Source files
------------

// File: rtl/servo_pwm_decoder.sv
// Servo PWM pulse-width decoder: measures the high time of servo_in_i, maps it to an 8-bit position,
// and flags over-long pulses and loss of lock. Optional glitch filter: SERVO_DEC_FILTER_EN.
module servo_pwm_decoder #(
  parameter int unsigned PULSE_MIN = 6000,
  parameter int unsigned STEP      = 94,
  parameter int unsigned PULSE_MAX = 36000,
  parameter int unsigned TIMEOUT   = 360000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       servo_in_i,
  output logic [7:0] position_o,
  output logic       valid_o,
  output logic       err_o,
  output logic       locked_o
);

  localparam int unsigned CntMax = (PULSE_MAX > TIMEOUT) ? PULSE_MAX : TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned PscW   = (STEP > 1) ? $clog2(STEP) : 1;

  localparam logic [CntW-1:0] PulseMinC = CntW'(PULSE_MIN);
  localparam logic [CntW-1:0] PulseMaxC = CntW'(PULSE_MAX);
  localparam logic [CntW-1:0] TimeoutC  = CntW'(TIMEOUT);
  localparam logic [PscW-1:0] PscLastC  = PscW'(STEP - 1);

  typedef enum logic [1:0] {
    StIdle,
    StOffset,
    StMeasure,
    StWaitLow
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            s_in;
  logic            s_prev_q;
  logic            rise, fall;
  logic [2:0]      prime_q;
  logic            primed;
  logic [CntW-1:0] width_q, width_d;
  logic [CntW-1:0] tmo_q, tmo_d;
  logic [PscW-1:0] psc_q, psc_d;
  logic [7:0]      step_q, step_d;
  logic [7:0]      pos_q, pos_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            locked_q, locked_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], servo_in_i};
    end
  end

`ifdef SERVO_DEC_FILTER_EN
  logic [1:0] fcnt_q, fcnt_d;
  logic       filt_q;

  // The 4th consecutive differing sample is passed through combinationally: 3 clocks of latency.
  always_comb begin
    s_in   = filt_q;
    fcnt_d = 2'd0;
    if (sync_q[1] != filt_q) begin
      if (fcnt_q == 2'd3) begin
        s_in = sync_q[1];
      end else begin
        fcnt_d = fcnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fcnt_q <= 2'd0;
      filt_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      filt_q <= s_in;
    end
  end
`else
  assign s_in = sync_q[1];
`endif

  assign rise   = s_in & ~s_prev_q;
  assign fall   = ~s_in & s_prev_q;
  // Synchronizer and filter are not trustworthy until a few clocks after reset.
  assign primed = &prime_q;

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    psc_d    = psc_q;
    step_d   = step_q;
    pos_d    = pos_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    tmo_d    = tmo_q;
    locked_d = locked_q;

    case (state_q)
      StIdle: begin
        if (rise) begin
          // The edge cycle is itself the first high clock.
          width_d = CntW'(1);
          psc_d   = '0;
          step_d  = 8'd0;
          state_d = StOffset;
        end
      end
      StOffset: begin
        if (fall) begin
          pos_d   = 8'd0;
          valid_d = 1'b1;
          state_d = StIdle;
        end else begin
          width_d = width_q + CntW'(1);
          if (width_d == PulseMaxC) begin
            err_d   = 1'b1;
            state_d = StWaitLow;
          end else if (width_d == PulseMinC) begin
            state_d = StMeasure;
          end
        end
      end
      StMeasure: begin
        if (fall) begin
          pos_d   = step_q;
          valid_d = 1'b1;
          state_d = StIdle;
        end else begin
          width_d = width_q + CntW'(1);
          if (width_d == PulseMaxC) begin
            err_d   = 1'b1;
            state_d = StWaitLow;
          end else if (psc_q == PscLastC) begin
            psc_d = '0;
            if (step_q != 8'd255) begin
              step_d = step_q + 8'd1;
            end
          end else begin
            psc_d = psc_q + PscW'(1);
          end
        end
      end
      StWaitLow: begin
        if (!s_in && primed) begin
          state_d = StIdle;
        end
      end
      default: state_d = StWaitLow;
    endcase

    if (valid_d) begin
      tmo_d    = '0;
      locked_d = 1'b1;
    end else begin
      if (tmo_q != TimeoutC) begin
        tmo_d = tmo_q + CntW'(1);
      end
      if (tmo_d == TimeoutC || err_d) begin
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StWaitLow;
      s_prev_q <= 1'b0;
      prime_q  <= 3'd0;
      width_q  <= '0;
      psc_q    <= '0;
      step_q   <= 8'd0;
      tmo_q    <= '0;
      pos_q    <= 8'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_prev_q <= s_in;
      if (!primed) begin
        prime_q <= prime_q + 3'd1;
      end
      width_q  <= width_d;
      psc_q    <= psc_d;
      step_q   <= step_d;
      tmo_q    <= tmo_d;
      pos_q    <= pos_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign position_o = pos_q;
  assign valid_o    = valid_q;
  assign err_o      = err_q;
  assign locked_o   = locked_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder with scaled timing parameters; a pulse-level model predicts every
// valid/err event, the held position and the lock level, checked on each falling clock edge.
module tb_servo_pwm_decoder;

  localparam int unsigned PMIN = 600;
  localparam int unsigned STP  = 10;
  localparam int unsigned PMAX = 3600;
  localparam int unsigned TMO  = 6000;
  localparam int          PER  = 2000;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       servo_in_i;
  logic [7:0] position_o;
  logic       valid_o;
  logic       err_o;
  logic       locked_o;

  servo_pwm_decoder #(
    .PULSE_MIN(PMIN),
    .STEP     (STP),
    .PULSE_MAX(PMAX),
    .TIMEOUT  (TMO)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .servo_in_i(servo_in_i),
    .position_o(position_o),
    .valid_o   (valid_o),
    .err_o     (err_o),
    .locked_o  (locked_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit is_err;
    int pos;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  rise_cyc = -100000;
  int  fall_cyc = -100000;
  int  nvalid = 0;
  int  nerr = 0;
  int  mpos = 0;
  bit  mlock = 1'b0;
  int  last_valid_cyc = 0;
  int  lock_fall_cyc = -1;
  bit  locked_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_pos(input int w);
    int r;
    if (w < int'(PMIN)) return 0;
    r = (w - int'(PMIN)) / int'(STP);
    return (r > 255) ? 255 : r;
  endfunction

  // Compare process: events against the queued predictions, levels against the model.
  always @(negedge clk_i) begin
    ev_t e;
    cyc++;
    if (rst_i) begin
      mpos  = 0;
      mlock = 1'b0;
      check("valid_in_reset", int'(valid_o), 0);
      check("err_in_reset", int'(err_o), 0);
    end else begin
      if (valid_o) begin
        nvalid++;
        if (exp_q.size() == 0 || exp_q[0].is_err) begin
          check("valid_expected", 1, 0);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          e = exp_q.pop_front();
          check("valid_position", int'(position_o), e.pos);
          check("valid_latency_ok", int'((cyc - fall_cyc) >= 3 && (cyc - fall_cyc) <= 10), 1);
          mpos = e.pos;
        end
        mlock          = 1'b1;
        last_valid_cyc = cyc;
      end
      if (err_o) begin
        nerr++;
        if (exp_q.size() == 0 || !exp_q[0].is_err) begin
          check("err_expected", 1, 0);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
          check("err_latency_ok",
                int'((cyc - rise_cyc) > int'(PMAX) && (cyc - rise_cyc) <= int'(PMAX) + 10), 1);
        end
        mlock = 1'b0;
      end
      if (mlock && (cyc - last_valid_cyc) >= int'(TMO)) mlock = 1'b0;
    end
    check("position_hold", int'(position_o), mpos);
    check("locked_level", int'(locked_o), int'(mlock));
    if (locked_prev && !locked_o && !rst_i) lock_fall_cyc = cyc;
    locked_prev = locked_o;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic pulse(input int w);
    ev_t e;
    bit  produces;
    int  low;
    produces = 1'b1;
`ifdef SERVO_DEC_FILTER_EN
    if (w <= 3) produces = 1'b0;
`endif
    if (produces) begin
      e.is_err = (w >= int'(PMAX));
      e.pos    = model_pos(w);
      exp_q.push_back(e);
    end
    low        = (w < PER - 200) ? PER - w : 1000;
    rise_cyc   = cyc;
    servo_in_i = 1'b1;
    cycles(w);
    fall_cyc   = cyc;
    servo_in_i = 1'b0;
    cycles(low);
  endtask

  initial begin
    #(150000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int v_before;
    rst_i      = 1'b1;
    servo_in_i = 1'b0;
    cycles(5);
    check("rst_position", int'(position_o), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_locked", int'(locked_o), 0);
    rst_i = 1'b0;
    cycles(20);

    repeat (3) pulse(1800);
    check("lit_pos_1800", int'(position_o), 120);
    check("lit_locked_1800", int'(locked_o), 1);
    check("lit_nvalid_3", nvalid, 3);
    check("lit_nerr_0", nerr, 0);

    pulse(480);  check("lit_pos_480", int'(position_o), 0);
    pulse(3150); check("lit_pos_3150", int'(position_o), 255);
    pulse(3149); check("lit_pos_3149", int'(position_o), 254);
    pulse(3400); check("lit_pos_3400", int'(position_o), 255);
    pulse(600);  check("lit_pos_600", int'(position_o), 0);
    pulse(609);  check("lit_pos_609", int'(position_o), 0);
    pulse(610);  check("lit_pos_610", int'(position_o), 1);

    v_before = nvalid;
    pulse(4000);
    check("lit_err_locked", int'(locked_o), 0);
    check("lit_err_count", nerr, 1);
    check("lit_err_no_valid", nvalid, v_before);
    check("lit_err_pos_kept", int'(position_o), 1);
    pulse(1800);
    check("lit_after_err_pos", int'(position_o), 120);
    check("lit_after_err_locked", int'(locked_o), 1);

    pulse(3599); check("lit_pos_3599", int'(position_o), 255);
    pulse(3600); check("lit_err_3600", nerr, 2);
    pulse(1800);

    lock_fall_cyc = -1;
    cycles(int'(TMO) + 200);
    check("lit_timeout_delta", lock_fall_cyc - last_valid_cyc, int'(TMO));
    check("lit_timeout_pos_kept", int'(position_o), 120);

    pulse(1800);
    v_before   = nvalid;
    servo_in_i = 1'b1;
    cycles(500);
    rst_i = 1'b1;
    cycles(3);
    check("midrst_position", int'(position_o), 0);
    check("midrst_locked", int'(locked_o), 0);
    check("midrst_valid", int'(valid_o), 0);
    rst_i = 1'b0;
    cycles(1000);
    servo_in_i = 1'b0;
    cycles(500);
    check("midrst_no_valid", nvalid, v_before);
    pulse(1800);
    check("lit_after_rst_pos", int'(position_o), 120);
    check("lit_after_rst_locked", int'(locked_o), 1);

    v_before = nvalid;
    pulse(3);
`ifdef SERVO_DEC_FILTER_EN
    check("glitch_rejected", nvalid, v_before);
`else
    check("glitch_decoded", nvalid, v_before + 1);
    check("glitch_pos", int'(position_o), 0);
`endif
    pulse(700);
    check("lit_pos_700", int'(position_o), 10);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
